encode: RTL and testbench

- Single-bit systematic/generator-matrix encoder slice for the LDPC FPGA datapath. Given a K-bit information word and one K-bit column of the generator matrix G, it produces one codeword bit: the GF(2) inner product (AND then XOR-reduce).
- A higher-level codeword builder instantiates or time-multiplexes this block N times (default codeword length N = 11, K = 6) to form the full codeword.
- The result is registered; latency is one clock cycle.

---
 rtl/encode.sv | 36 +++
 tb/tb_encode.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/encode.sv
// Generator-matrix encoder slice: one codeword bit as the GF(2) inner product
// of an information word and one generator column, registered with 1-cycle latency.
module encode #(
    parameter int unsigned K = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [K-1:0] info_bits,
    input  logic [K-1:0] generator_col,
    output logic         code_bit,
    output logic         out_valid
);

    logic [K-1:0] product;
    logic         code_bit_next;

    // Reduction XOR maps to a balanced tree of depth ceil(log2 K); no pipelining.
    always_comb begin
        product       = info_bits & generator_col;
        code_bit_next = ^product;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_bit  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                code_bit <= code_bit_next;
            end
        end
    end

endmodule

// File: tb/tb_encode.sv
// Scoreboard bench for encode: K = 1, 6 and 64 instances driven side by side,
// each compared against a popcount-parity model with one cycle of delay.
module tb_encode;

    typedef struct packed {
        logic v;
        logic b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        iv1, ib1, gc1, cb1, ov1;
    logic        iv6, cb6, ov6;
    logic [5:0]  ib6, gc6;
    logic        iv64, cb64, ov64;
    logic [63:0] ib64, gc64;

    exp_t q1[$];
    exp_t q6[$];
    exp_t q64[$];

    logic m1, m6, m64;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    encode #(.K(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .info_bits(ib1),
        .generator_col(gc1), .code_bit(cb1), .out_valid(ov1)
    );

    encode #(.K(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(iv6), .info_bits(ib6),
        .generator_col(gc6), .code_bit(cb6), .out_valid(ov6)
    );

    encode #(.K(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .info_bits(ib64),
        .generator_col(gc64), .code_bit(cb64), .out_valid(ov64)
    );

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic parity(input logic [63:0] x);
        return logic'($countones(x) % 2);
    endfunction

    task automatic pop_check(input string tag, inout exp_t q[$], input logic ov, input logic cb);
        exp_t e;
        if (q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 1'b1, 1'b0);
            return;
        end
        e = q.pop_front();
        check_eq({tag, "_valid"}, ov, e.v);
        check_eq({tag, "_bit"}, cb, e.b);
    endtask

    // One clock: drive at negedge, predict, then compare just after posedge.
    task automatic step(input logic r, input logic [2:0] v,
                        input logic [63:0] info, input logic [63:0] col);
        @(negedge clk);
        rst  = r;
        iv1  = v[0];  ib1  = info[0];   gc1  = col[0];
        iv6  = v[1];  ib6  = info[5:0]; gc6  = col[5:0];
        iv64 = v[2];  ib64 = info;      gc64 = col;
        if (r) begin
            m1 = 1'b0; m6 = 1'b0; m64 = 1'b0;
            q1.push_back('{v: 1'b0, b: 1'b0});
            q6.push_back('{v: 1'b0, b: 1'b0});
            q64.push_back('{v: 1'b0, b: 1'b0});
        end else begin
            if (v[0]) m1  = parity({63'd0, info[0] & col[0]});
            if (v[1]) m6  = parity({58'd0, info[5:0] & col[5:0]});
            if (v[2]) m64 = parity(info & col);
            q1.push_back('{v: v[0], b: m1});
            q6.push_back('{v: v[1], b: m6});
            q64.push_back('{v: v[2], b: m64});
        end
        @(posedge clk);
        #1;
        pop_check("k1", q1, ov1, cb1);
        pop_check("k6", q6, ov6, cb6);
        pop_check("k64", q64, ov64, cb64);
    endtask

    initial begin
        logic [63:0] ri, rc;
        logic [2:0]  rv;
        rst = 1'b1;
        iv1 = 1'b0; iv6 = 1'b0; iv64 = 1'b0;
        ib1 = 1'b0; gc1 = 1'b0; ib6 = '0; gc6 = '0; ib64 = '0; gc64 = '0;
        m1 = 1'b0; m6 = 1'b0; m64 = 1'b0;

        // Reset held with valid, nonzero inputs, then released idle.
        step(1'b1, 3'b111, '1, '1);
        step(1'b1, 3'b111, 64'h3F, 64'h15);
        step(1'b0, 3'b000, '1, '1);

        // Column sweep with info = 111111.
        for (int unsigned c = 0; c < 6; c++) begin
            step(1'b0, 3'b010, 64'h3F, 64'(c));
        end

        // Masking with info = 101010.
        step(1'b0, 3'b010, 64'h2A, 64'h3F);
        step(1'b0, 3'b010, 64'h2A, 64'h15);
        step(1'b0, 3'b010, 64'h2A, 64'h0A);
        step(1'b0, 3'b010, 64'h2A, 64'h20);

        // Hold: result 1, then idle with changing and unknown inputs.
        step(1'b0, 3'b111, 64'h2A, 64'h3F);
        step(1'b0, 3'b000, 64'h15, 64'h15);
        step(1'b0, 3'b000, 'x, 'x);
        step(1'b0, 3'b000, '1, 64'h01);

        // Reset wins over in_valid with parity-1 inputs, then resume.
        step(1'b1, 3'b111, 64'h01, 64'h01);
        step(1'b0, 3'b111, 64'h07, 64'h01);

        // Boundaries: all ones gives K mod 2; zero operands give 0.
        step(1'b0, 3'b111, '1, '1);
        step(1'b0, 3'b111, {$urandom, $urandom}, '0);
        step(1'b0, 3'b111, '0, {$urandom, $urandom});

        // Random, back-to-back valid.
        for (int i = 0; i < 1000; i++) begin
            ri = {$urandom, $urandom};
            rc = {$urandom, $urandom};
            step(1'b0, 3'b111, ri, rc);
        end

        // Random with gaps and occasional mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            ri = {$urandom, $urandom};
            rc = {$urandom, $urandom};
            rv = 3'($urandom);
            step(($urandom_range(0, 29) == 0), rv, ri, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, observed running expected finished");
        $fatal(1);
    end

endmodule
